// File: rtl/instruction_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : instruction_fetch (plus common_pkg)
// Description : PC register and fetch sequencer. It keeps one memory request
//               outstanding, holds the returned word for decode, and handles
//               branch redirects and flushes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

package common_pkg;
    localparam int INSTRUCTION_WIDTH = 32;
endpackage

module instruction_fetch #(
    parameter int                    ADDR_WIDTH        = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0,
    parameter int                    INSTRUCTION_WIDTH = common_pkg::INSTRUCTION_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,

    output logic                         imem_req,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,

    output logic                         if_valid,
    input  logic                         if_ready,
    output logic [INSTRUCTION_WIDTH-1:0] if_instruction,
    output logic [ADDR_WIDTH-1:0]        if_pc,

    input  logic                         redirect,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    input  logic signed [63:0]           redirect_offset,

    output logic                         fetch_fault
);

    localparam logic [ADDR_WIDTH-1:0] c_pc_step = ADDR_WIDTH'(4);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DROP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t                         r_state;
    logic [ADDR_WIDTH-1:0]          r_pc;
    logic                           r_imem_req;
    logic                           r_if_valid;
    logic [INSTRUCTION_WIDTH-1:0]   r_if_instruction;
    logic [ADDR_WIDTH-1:0]          r_if_pc;
    logic                           r_fetch_fault;

    logic signed [63:0]             w_offset_x2;
    logic [ADDR_WIDTH-1:0]          w_target;
    logic                           w_misaligned;
    logic                           w_gnt;
    logic                           w_redirect;

    // Offset is in half-words; the signed cast sign-extends before the wrap-around add.
    assign w_offset_x2  = redirect_offset <<< 1;
    assign w_target     = redirect_pc + ADDR_WIDTH'(w_offset_x2);
    assign w_misaligned = |w_target[1:0];
    assign w_gnt        = r_imem_req && imem_gnt;
    assign w_redirect   = redirect && (r_state != S_FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_REQ;
            r_pc             <= RESET_PC;
            r_imem_req       <= 1'b0;
            r_if_valid       <= 1'b0;
            r_if_instruction <= '0;
            r_if_pc          <= '0;
            r_fetch_fault    <= 1'b0;
        end else if (w_redirect) begin
            r_pc       <= w_target;
            r_if_valid <= 1'b0;
            if (w_misaligned) begin
                r_fetch_fault <= 1'b1;
                r_imem_req    <= 1'b0;
                r_state       <= S_FAULT;
            end else begin
                case (r_state)
                    S_REQ: begin
                        // A grant this cycle leaves a response for the old pc in flight.
                        if (w_gnt) begin
                            r_imem_req <= 1'b0;
                            r_state    <= S_DROP;
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                    S_WAIT, S_DROP: begin
                        if (imem_rvalid) begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_REQ;
                        end else begin
                            r_imem_req <= 1'b0;
                            r_state    <= S_DROP;
                        end
                    end
                    default: begin
                        r_imem_req <= 1'b1;
                        r_state    <= S_REQ;
                    end
                endcase
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_gnt) begin
                        r_imem_req <= 1'b0;
                        r_state    <= S_WAIT;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_if_instruction <= imem_rdata;
                        r_if_pc          <= r_pc;
                        r_if_valid       <= 1'b1;
                        r_pc             <= r_pc + c_pc_step;
                        r_state          <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        r_if_valid <= 1'b0;
                        r_imem_req <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        r_imem_req <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_FAULT: begin
                    r_imem_req <= 1'b0;
                    r_if_valid <= 1'b0;
                end
                default: begin
                    r_imem_req <= 1'b0;
                    r_if_valid <= 1'b0;
                    r_state    <= S_FAULT;
                end
            endcase
        end
    end

    assign imem_req       = r_imem_req;
    assign imem_addr      = r_pc;
    assign if_valid       = r_if_valid;
    assign if_instruction = r_if_instruction;
    assign if_pc          = r_if_pc;
    assign fetch_fault    = r_fetch_fault;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch with a small memory model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic signed [63:0] redirect_offset;
    logic        fetch_fault;

    instruction_fetch #(
        .ADDR_WIDTH (64),
        .RESET_PC   (64'h0)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .redirect_offset (redirect_offset),
        .fetch_fault     (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic [63:0] exp_req_q[$];
    fetch_t      exp_fetch_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    int          hs_count = 0;
    int          hs_cycle[$];
    int          gnt_delay = 1;
    int          rsp_delay = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic push_fetch(input logic [63:0] pc, input logic [31:0] instr);
        fetch_t f;
        f.pc    = pc;
        f.instr = instr;
        exp_fetch_q.push_back(f);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h00:  return 32'h00F23403;
            64'h04:  return 32'h82823BA3;
            64'h08:  return 32'hA4820F63;
            64'h40:  return 32'h00000013;
            64'h44:  return 32'h00100093;
            default: return 32'hDEAD0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    // Memory: grants after gnt_delay request cycles, answers rsp_delay cycles after the grant.
    initial begin : mem_model
        bit          pend;
        int          cnt;
        int          age;
        logic [63:0] paddr;
        pend = 0; cnt = 0; age = 0; paddr = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (reset) begin
                pend = 0; cnt = 0; age = 0;
                imem_rdata = '0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(paddr);
                        pend        = 0;
                    end
                end
                if (imem_req && !pend) begin
                    age++;
                    if (age > gnt_delay) begin
                        imem_gnt = 1'b1;
                        pend     = 1;
                        cnt      = rsp_delay;
                        paddr    = imem_addr;
                        age      = 0;
                    end
                end else begin
                    age = 0;
                end
            end
        end
    end

    initial begin : monitor
        logic        prev_stall;
        logic [31:0] prev_instr;
        logic [63:0] prev_pc;
        logic [63:0] e_addr;
        fetch_t      e_f;
        prev_stall = 1'b0; prev_instr = '0; prev_pc = '0;
        forever begin
            @(negedge clk);
            #1;
            cycle++;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (imem_req && imem_gnt) begin
                    if (exp_req_q.size() == 0) begin
                        check("req_unexpected", imem_addr, 64'hX);
                    end else begin
                        e_addr = exp_req_q.pop_front();
                        check("imem_addr", imem_addr, e_addr);
                    end
                end
                if (if_valid && if_ready) begin
                    hs_count++;
                    hs_cycle.push_back(cycle);
                    if (exp_fetch_q.size() == 0) begin
                        check("fetch_unexpected_pc", if_pc, 64'hX);
                    end else begin
                        e_f = exp_fetch_q.pop_front();
                        check("if_pc", if_pc, e_f.pc);
                        check("if_instruction", {32'h0, if_instruction}, {32'h0, e_f.instr});
                    end
                end
                if (prev_stall) begin
                    check("stall_valid", {63'h0, if_valid}, 64'h1);
                    check("stall_pc", if_pc, prev_pc);
                    check("stall_instr", {32'h0, if_instruction}, {32'h0, prev_instr});
                end
                if (if_valid)
                    check("req_while_holding", {63'h0, imem_req}, 64'h0);
                if (fetch_fault)
                    check("fault_quiet", {62'h0, imem_req, if_valid}, 64'h0);
                prev_stall = if_valid && !if_ready && !redirect;
                prev_instr = if_instruction;
                prev_pc    = if_pc;
            end
        end
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (!if_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!if_valid) fail_now(name);
    endtask

    task automatic wait_hs(input int target, input string name);
        int n = 0;
        while (hs_count < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (hs_count < target) fail_now(name);
    endtask

    // The fetcher is in WAIT on the first cycle where the request drops without if_valid.
    task automatic wait_wait_state(input string name);
        logic prev;
        int   n;
        bit   found;
        prev  = imem_req;
        n     = 0;
        found = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            if (prev && !imem_req && !if_valid) found = 1;
            prev = imem_req;
        end
        if (!found) fail_now(name);
    endtask

    initial begin : stimulus
        int base;
        reset = 1'b1; if_ready = 1'b0; redirect = 1'b0;
        redirect_pc = '0; redirect_offset = '0;
        repeat (3) @(negedge clk);
        check("rst_imem_req", {63'h0, imem_req}, 64'h0);
        check("rst_if_valid", {63'h0, if_valid}, 64'h0);
        check("rst_if_instruction", {32'h0, if_instruction}, 64'h0);
        check("rst_if_pc", if_pc, 64'h0);
        check("rst_fetch_fault", {63'h0, fetch_fault}, 64'h0);
        check("rst_imem_addr", imem_addr, 64'h0);

        // Sequential fetch
        exp_req_q.push_back(64'h0);
        exp_req_q.push_back(64'h4);
        push_fetch(64'h0, 32'h00F23403);
        push_fetch(64'h4, 32'h82823BA3);
        @(posedge clk); #3 reset = 1'b0;
        @(negedge clk);
        check("no_req_first_cycle", {63'h0, imem_req}, 64'h0);
        if_ready = 1'b1;
        wait_hs(2, "seq_fetch");
        if (hs_cycle.size() >= 2)
            check("fetch_period", 64'(hs_cycle[1] - hs_cycle[0]), 64'd4);

        // Async reset in the middle of WAIT for pc 8
        if_ready  = 1'b0;
        rsp_delay = 3;
        exp_req_q.push_back(64'h8);
        wait_wait_state("reach_wait_8");
        @(posedge clk); #3 reset = 1'b1;
        #1;
        check("arst_imem_req", {63'h0, imem_req}, 64'h0);
        check("arst_if_valid", {63'h0, if_valid}, 64'h0);
        check("arst_fetch_fault", {63'h0, fetch_fault}, 64'h0);
        check("arst_imem_addr", imem_addr, 64'h0);
        rsp_delay = 1;
        exp_req_q.push_back(64'h0);
        push_fetch(64'h0, 32'h00F23403);
        repeat (2) @(negedge clk);
        @(posedge clk); #3 reset = 1'b0;

        // Backpressure: hold decode off for 5 cycles
        wait_valid("bp_valid");
        repeat (5) @(negedge clk);
        rsp_delay = 3;
        exp_req_q.push_back(64'h4);
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
        check("bp_req_after_hs", {63'h0, imem_req}, 64'h1);
        check("bp_addr_after_hs", imem_addr, 64'h4);
        check("bp_valid_cleared", {63'h0, if_valid}, 64'h0);

        // Flush in flight: redirect to 0x40 while the fetch of 4 is outstanding
        wait_wait_state("reach_wait_4");
        base = hs_count;
        redirect = 1'b1; redirect_pc = 64'h0; redirect_offset = 64'sd32;
        if_ready = 1'b1;
        rsp_delay = 1;
        exp_req_q.push_back(64'h40);
        push_fetch(64'h40, 32'h00000013);
        @(negedge clk);
        redirect = 1'b0;
        check("flush_req_low", {63'h0, imem_req}, 64'h0);
        check("flush_pc", imem_addr, 64'h40);
        check("flush_valid_low", {63'h0, if_valid}, 64'h0);
        wait_hs(base + 1, "flush_fetch_40");

        // Redirect and handshake in the same HOLD cycle
        if_ready = 1'b0;
        exp_req_q.push_back(64'h44);
        push_fetch(64'h44, 32'h00100093);
        wait_valid("sim_valid_44");
        base = hs_count;
        redirect = 1'b1; redirect_pc = 64'h44; redirect_offset = -64'sd16;
        if_ready = 1'b1;
        exp_req_q.push_back(64'h24);
        @(negedge clk);
        redirect = 1'b0;
        if_ready = 1'b0;
        check("sim_valid_low", {63'h0, if_valid}, 64'h0);
        check("sim_req", {63'h0, imem_req}, 64'h1);
        check("sim_target", imem_addr, 64'h24);
        repeat (2) @(negedge clk);
        check("sim_single_hs", 64'(hs_count - base), 64'd1);

        // Misaligned branch target from HOLD: beq with offset -1745 at 0x100
        wait_valid("fault_valid_24");
        redirect = 1'b1; redirect_pc = 64'h100; redirect_offset = -64'sd1745;
        @(negedge clk);
        redirect = 1'b0;
        if_ready = 1'b1;
        check("fault_flag", {63'h0, fetch_fault}, 64'h1);
        check("fault_valid_low", {63'h0, if_valid}, 64'h0);
        check("fault_no_req", {63'h0, imem_req}, 64'h0);
        check("fault_target", imem_addr, 64'hFFFF_FFFF_FFFF_F35E);
        repeat (10) @(negedge clk);
        check("fault_sticky", {63'h0, fetch_fault}, 64'h1);
        check("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
        check("fetch_queue_empty", 64'(exp_fetch_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        fail_now("watchdog");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
